dct_2d_ctrl: RTL

- Sequencer for the 16x16 block 2D DCT datapath (row DCT stage, transpose buffer, column DCT stage) sitting between the input image memory and the coefficient output memory.
- On `start`, walks the image block by block in raster order and issues input-memory reads, row-stage valids, transpose-buffer write/read strobes and addresses, column-stage valids, and output-memory writes.
- Blocks are processed strictly sequentially, so the single transpose buffer is never shared between two blocks.

---
 rtl/dct_2d_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dct_2d_ctrl.sv
// dct_2d_ctrl: sequencer for a 16x16 block 2D DCT datapath.
// Walks the image one block at a time in raster order. For each block it reads
// 16 input words, waits for the row DCT to write the transpose buffer, reads the
// 16 buffer columns, waits for the column DCT and emits 16 output writes.
// Downstream strobes come from fixed-latency delay lines on the read enables.
module dct_2d_ctrl #(
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 512,
    parameter int N       = 16,
    parameter int AW      = 14,
    parameter int MEM_LAT = 1,
    parameter int ROW_LAT = 2,
    parameter int COL_LAT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          in_rd_en,
    output logic [AW-1:0] in_addr,
    output logic          row_vld,
    output logic          tp_wr_en,
    output logic [3:0]    tp_wr_addr,
    output logic          tp_rd_en,
    output logic [3:0]    tp_rd_addr,
    output logic          col_vld,
    output logic          out_wr_en,
    output logic [AW-1:0] out_addr,
    output logic [AW-5:0] blk_idx
);

    localparam int BPR    = IMG_W / N;
    localparam int BPC    = IMG_H / N;
    localparam int NBLK   = BPR * BPC;
    localparam int BW     = AW - 4;
    localparam int RW_LEN = MEM_LAT + ROW_LAT;
    localparam int CW_LEN = 1 + COL_LAT;
    localparam int CMAX   = (N > RW_LEN) ? ((N > CW_LEN) ? N : CW_LEN)
                                         : ((RW_LEN > CW_LEN) ? RW_LEN : CW_LEN);
    localparam int CNTW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ROW_RD,
        ROW_WAIT,
        COL_RD,
        COL_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CNTW-1:0] cnt;
    logic [BW-1:0]   bx;
    logic [BW-1:0]   by;
    logic [3:0]      out_k;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        in_rd_en = 1'b0;
        tp_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ROW_RD;
                end
            end
            ROW_RD: begin
                busy     = 1'b1;
                in_rd_en = 1'b1;
                if (cnt == CNTW'(N - 1)) begin
                    state_d = ROW_WAIT;
                end
            end
            ROW_WAIT: begin
                busy = 1'b1;
                if (cnt == CNTW'(RW_LEN - 1)) begin
                    state_d = COL_RD;
                end
            end
            COL_RD: begin
                busy     = 1'b1;
                tp_rd_en = 1'b1;
                if (cnt == CNTW'(N - 1)) begin
                    state_d = COL_WAIT;
                end
            end
            COL_WAIT: begin
                busy = 1'b1;
                if (cnt == CNTW'(CW_LEN - 1)) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                busy = 1'b1;
                if (blk_idx == BW'(NBLK - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = ROW_RD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-state cycle counter, restarted on every state change and held at 0 in IDLE
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNTW'(1);
        end
    end

    // Block position: linear index plus its column/row so addresses need no divider
    always_ff @(posedge clk) begin
        if (!rstn) begin
            blk_idx <= '0;
            bx      <= '0;
            by      <= '0;
        end else if (state_q == DONE) begin
            blk_idx <= '0;
            bx      <= '0;
            by      <= '0;
        end else if ((state_q == NEXT) && (state_d == ROW_RD)) begin
            blk_idx <= blk_idx + BW'(1);
            if (bx == BW'(BPR - 1)) begin
                bx <= '0;
                by <= by + BW'(1);
            end else begin
                bx <= bx + BW'(1);
            end
        end
    end

    assign in_addr    = in_rd_en ? AW'((32'(by) * 32'(N) + 32'(cnt)) * 32'(BPR) + 32'(bx)) : '0;
    assign tp_rd_addr = tp_rd_en ? cnt[3:0] : 4'd0;
    assign out_addr   = AW'(32'(blk_idx) * 32'(N) + 32'(out_k));

    logic [MEM_LAT-1:0] rd_dly;

    // Input-memory latency: row data is valid MEM_LAT cycles after the read
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_dly <= '0;
        end else begin
            rd_dly[0] <= in_rd_en;
            for (int i = 1; i < MEM_LAT; i++) begin
                rd_dly[i] <= rd_dly[i-1];
            end
        end
    end

    assign row_vld = rd_dly[MEM_LAT-1];

    generate
        if (ROW_LAT == 0) begin : g_row_nodly
            assign tp_wr_en = row_vld;
        end else begin : g_row_dly
            logic [ROW_LAT-1:0] dly;

            // Row DCT pipeline latency between row_vld and the buffer write
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dly <= '0;
                end else begin
                    dly[0] <= row_vld;
                    for (int i = 1; i < ROW_LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign tp_wr_en = dly[ROW_LAT-1];
        end
    endgenerate

    // Transpose buffer has a one-cycle read latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_vld <= 1'b0;
        end else begin
            col_vld <= tp_rd_en;
        end
    end

    generate
        if (COL_LAT == 0) begin : g_col_nodly
            assign out_wr_en = col_vld;
        end else begin : g_col_dly
            logic [COL_LAT-1:0] dly;

            // Column DCT pipeline latency between col_vld and the output write
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dly <= '0;
                end else begin
                    dly[0] <= col_vld;
                    for (int i = 1; i < COL_LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign out_wr_en = dly[COL_LAT-1];
        end
    endgenerate

    // Transpose row index; 16 writes per block bring it back to 0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tp_wr_addr <= 4'd0;
        end else if (tp_wr_en) begin
            tp_wr_addr <= tp_wr_addr + 4'd1;
        end
    end

    // Output word offset within the block; 16 writes per block bring it back to 0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_k <= 4'd0;
        end else if (out_wr_en) begin
            out_k <= out_k + 4'd1;
        end
    end

endmodule
